lsu_v1: RTL and testbench

Load/store unit: the initiator that drives the memory unit's word-wide port (`mem_addr`, `data_in`, `data_out`, `write_enable`, `read_enable`) on behalf of the core pipeline. It accepts one RISC-V load/store at a time from the execute stage and performs alignment checks and byte-lane extraction with sign/zero extension. Sub-word stores are done as read-modify-write, because the memory unit only writes full words. It then returns one response per request.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align_v1.sv | 63 ++++++
 rtl/lsu_v1.sv | 166 ++++++++++++++++
 tb/tb_lsu_v1.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_v1 load/store unit.
// Optional build macro: LSU_RANGE_CHECK_EN (used by lsu_v1).
package lsu_pkg;

  localparam int LSU_MAX_RD_LATENCY = 3;

  // RISC-V load/store width codes; stores reuse LB/LH/LW for SB/SH/SW
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } lsu_width_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RMW_WAIT,
    ST_WR,
    ST_RESP,
    ST_ERR
  } lsu_state_e;

  // Codes with no meaning for the given direction
  function automatic logic funct3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  // Halfwords need an even address, words need a multiple of four
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align_v1.sv
// Byte-lane steering for lsu_v1: load extract with sign/zero extension and
// sub-word store merge into a previously read word. Purely combinational.
module lsu_align_v1
  import lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte and halfword of the loaded word
  always_comb begin
    lane_byte = load_word[7:0];
    case (byte_off)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    lane_half = byte_off[1] ? load_word[31:16] : load_word[15:0];
  end

  // Extend the selected lane to a full register value
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_data = load_word;
      F3_LBU:  load_data = {24'd0, lane_byte};
      F3_LHU:  load_data = {16'd0, lane_half};
      default: load_data = '0;
    endcase
  end

  // Overlay the low byte/halfword of the store data onto the old word
  always_comb begin
    merged_word = old_word;
    case (funct3[1:0])
      2'b00: begin
        case (byte_off)
          2'd0:    merged_word[7:0]   = new_data[7:0];
          2'd1:    merged_word[15:8]  = new_data[7:0];
          2'd2:    merged_word[23:16] = new_data[7:0];
          default: merged_word[31:24] = new_data[7:0];
        endcase
      end
      2'b01: begin
        if (byte_off[1]) merged_word[31:16] = new_data[15:0];
        else             merged_word[15:0]  = new_data[15:0];
      end
      default: merged_word = new_data;
    endcase
  end

endmodule

// File: rtl/lsu_v1.sv
// Load/store unit driving a word-wide memory port. One request at a time;
// sub-word stores are done as read-modify-write.
// Optional build macro: LSU_RANGE_CHECK_EN -- reject byte addresses beyond
// the memory; when undefined, upper address bits are ignored (aliasing).
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// RD       | read strobe asserted for one cycle
// RD_WAIT  | waiting RD_LATENCY cycles for load data
// RMW_WAIT | waiting RD_LATENCY cycles for the word to merge into
// WR       | write strobe asserted with the final word
// RESP     | resp_valid pulse for a completed access
// ERR      | resp_valid + resp_err pulse, no memory access made
module lsu_v1
  import lsu_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_data_out,
  input  logic [data_width-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable
);

  localparam int CNT_W = $clog2(LSU_MAX_RD_LATENCY);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LATENCY - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;

  logic        accept;
  logic        range_err;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept = req_valid && req_ready;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:addr_width+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:addr_width+2];
  assign range_err = 1'b0;
`endif

  assign req_err = range_err || funct3_illegal(req_funct3, req_we)
                || misaligned(req_funct3, req_addr[1:0]);

  lsu_align_v1 u_align (
    .load_word   (mem_data_in),
    .old_word    (mem_data_in),
    .new_data    (wdata_q),
    .byte_off    (off_q),
    .funct3      (f3_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Request sequencing with all port outputs registered; strobes and the
  // response are single-cycle pulses defaulted low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      we_q             <= 1'b0;
      f3_q             <= '0;
      off_q            <= '0;
      wdata_q          <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      mem_addr         <= '0;
      mem_data_out     <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_data_out     <= '0;
      resp_valid       <= 1'b0;
      resp_err         <= 1'b0;
      resp_rdata       <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[addr_width+1:2];
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= ST_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_LW)) begin
              state            <= ST_WR;
              mem_write_enable <= 1'b1;
              mem_data_out     <= req_wdata;
            end else begin
              state           <= ST_RD;
              mem_read_enable <= 1'b1;
            end
          end
        end
        ST_RD: begin
          wait_cnt <= WAIT_INIT;
          state    <= we_q ? ST_RMW_WAIT : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RMW_WAIT: begin
          if (wait_cnt == '0) begin
            mem_data_out     <= merged_word;
            mem_write_enable <= 1'b1;
            state            <= ST_WR;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP, ST_ERR: begin
          mem_addr  <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          mem_addr  <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_v1.sv
// Self-checking bench for lsu_v1 with a behavioural memory unit and a
// word-array reference model of RISC-V load/store semantics.
module tb_lsu_v1;
  localparam int AW    = 10;
  localparam int LAT   = 1;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_out, mem_data_in;
  logic          mem_write_enable, mem_read_enable;

  lsu_v1 #(.addr_width(AW), .data_width(32), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory unit model ----------------
  function automatic logic [31:0] init_val(input int a);
    return (32'h9E3779B9 * (a + 1)) ^ 32'hC3A50F1E;
  endfunction

  logic [31:0]       mem [WORDS];
  bit   [WORDS-1:0]  mem_valid;
  logic [AW-1:0]     rd_pipe [LAT];
  logic              bd_we = 1'b0;
  logic [AW-1:0]     bd_addr = '0;
  logic [31:0]       bd_data = '0;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr]       <= mem_data_out;
      mem_valid[mem_addr] <= 1'b1;
    end
    if (bd_we) begin
      mem[bd_addr]       <= bd_data;
      mem_valid[bd_addr] <= 1'b1;
    end
    rd_pipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  always_comb begin
    mem_data_in = mem_valid[rd_pipe[LAT-1]] ? mem[rd_pipe[LAT-1]] : init_val(int'(rd_pipe[LAT-1]));
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [WORDS];

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    if (we) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!bad && (f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) bad = 1'b1;
    if (!bad && f3 == 3'd2 && (a % 4 != 0)) bad = 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if (a >= 32'(4 * WORDS)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    case (f3)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(s[15:0]));
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    if (f3 == 3'd2) return d;
    mask = ((f3 == 3'd1) ? 32'hFFFF : 32'hFF) << (8 * int'(off));
    return (w & ~mask) | ((d << (8 * int'(off))) & mask);
  endfunction

  task automatic bd_write(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = AW'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // ---------------- transaction driver (records, does not judge) ----------------
  int            o_wait, o_rd_cyc, o_wr_cyc, o_resp_cyc, o_nrd, o_nwr, o_both;
  logic [31:0]   o_wr_data, o_rdata;
  logic          o_err;
  logic [AW-1:0] o_rd_addr, o_wr_addr;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    o_wait = 0; o_rd_cyc = -1; o_wr_cyc = -1; o_resp_cyc = -1;
    o_nrd = 0; o_nwr = 0; o_both = 0;
    o_wr_data = '0; o_rdata = '0; o_err = 1'b0; o_rd_addr = '0; o_wr_addr = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && o_wait < 20) begin
      @(negedge clk);
      o_wait++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read_enable && mem_write_enable) o_both++;
      if (mem_read_enable) begin
        o_nrd++;
        if (o_rd_cyc < 0) begin o_rd_cyc = k; o_rd_addr = mem_addr; end
      end
      if (mem_write_enable) begin
        o_nwr++; o_wr_cyc = k; o_wr_data = mem_data_out; o_wr_addr = mem_addr;
      end
      if (resp_valid) begin
        o_resp_cyc = k; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, mem_read_enable, mem_write_enable} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {resp_valid, resp_err, mem_read_enable, mem_write_enable});
    end
    checks++;
    if (mem_addr !== '0 || mem_data_out !== '0 || resp_rdata !== '0) begin
      errors++; $display("FAIL reset_data got addr %h wd %h rd %h exp zeros", mem_addr, mem_data_out, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_extract();
    bd_write(3, 32'h80FF_7F01);
    do_req(1'b0, 3'b000, 32'h0F, '0);
    checks++;
    if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_0f rdata got %h exp ffffff80", o_rdata); end
    checks++;
    if (o_rd_cyc !== 1 || o_rd_addr !== AW'(3)) begin
      errors++; $display("FAIL lb_0f rd_strobe got cyc %0d addr %0d exp cyc 1 addr 3", o_rd_cyc, o_rd_addr);
    end
    checks++;
    if (o_resp_cyc !== 2 + LAT) begin errors++; $display("FAIL lb_0f resp_cyc got %0d exp %0d", o_resp_cyc, 2 + LAT); end
    @(negedge clk);
    // lane 2 of 0x80FF7F01 holds 0xFF
    do_req(1'b0, 3'b000, 32'h0E, '0);
    checks++;
    if (o_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_0e rdata got %h exp ffffffff", o_rdata); end
    @(negedge clk);
    do_req(1'b0, 3'b101, 32'h0C, '0);
    checks++;
    if (o_rdata !== 32'h0000_7F01) begin errors++; $display("FAIL lhu_0c rdata got %h exp 00007f01", o_rdata); end
    @(negedge clk);
    do_req(1'b0, 3'b001, 32'h0E, '0);
    checks++;
    if (o_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_0e rdata got %h exp ffff80ff", o_rdata); end
    @(negedge clk);
  endtask

  task automatic test_store_rmw();
    bd_write(2, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h09, 32'h0000_00AB);
    checks++;
    if (o_rd_cyc !== 1 || o_nrd !== 1) begin errors++; $display("FAIL sb_09 rd got cyc %0d n %0d exp cyc 1 n 1", o_rd_cyc, o_nrd); end
    checks++;
    if (o_wr_cyc !== 2 + LAT || o_wr_data !== 32'h1122_AB44 || o_wr_addr !== AW'(2)) begin
      errors++; $display("FAIL sb_09 wr got cyc %0d data %h addr %0d exp cyc %0d data 1122ab44 addr 2", o_wr_cyc, o_wr_data, o_wr_addr, 2 + LAT);
    end
    checks++;
    if (o_resp_cyc !== 3 + LAT || o_rdata !== '0) begin
      errors++; $display("FAIL sb_09 resp got cyc %0d rdata %h exp cyc %0d rdata 0", o_resp_cyc, o_rdata, 3 + LAT);
    end
    ref_mem[2] = 32'h1122_AB44;
    @(negedge clk);
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b010, 32'h06, '0);
    checks++;
    if (o_err !== 1'b1 || o_resp_cyc !== 1 || o_nrd !== 0 || o_nwr !== 0 || o_rdata !== '0) begin
      errors++; $display("FAIL lw_06 got err %b cyc %0d nrd %0d nwr %0d rdata %h exp err 1 cyc 1 no strobes",
                         o_err, o_resp_cyc, o_nrd, o_nwr, o_rdata);
    end
    @(negedge clk);
    do_req(1'b0, 3'b010, 32'h1000, '0);
`ifdef LSU_RANGE_CHECK_EN
    checks++;
    if (o_err !== 1'b1 || o_resp_cyc !== 1 || o_nrd !== 0) begin
      errors++; $display("FAIL lw_1000 got err %b cyc %0d nrd %0d exp err 1 cyc 1 nrd 0", o_err, o_resp_cyc, o_nrd);
    end
`else
    checks++;
    if (o_err !== 1'b0 || o_rdata !== ref_mem[0] || o_rd_addr !== '0) begin
      errors++; $display("FAIL lw_1000_alias got err %b rdata %h addr %0d exp err 0 rdata %h addr 0", o_err, o_rdata, o_rd_addr, ref_mem[0]);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (o_resp_cyc !== 2 || o_wr_cyc !== 1 || o_nrd !== 0 || o_wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_10 got resp %0d wr %0d nrd %0d data %h exp resp 2 wr 1 nrd 0 data deadbeef",
                         o_resp_cyc, o_wr_cyc, o_nrd, o_wr_data);
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    do_req(1'b0, 3'b010, 32'h10, '0);
    checks++;
    if (o_wait !== 1) begin errors++; $display("FAIL b2b_wait got %0d exp 1", o_wait); end
    checks++;
    if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
      errors++; $display("FAIL b2b_lw got %h err %b exp deadbeef err 0", o_rdata, o_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad_cycles;
    int nrd;
    nrd = 0;
    bad_cycles = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    if (mem_read_enable) nrd++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (mem_write_enable || resp_valid) bad_cycles++;
      @(negedge clk);
    end
    rst = 1'b0;
    checks++;
    if (nrd !== 1) begin errors++; $display("FAIL rstmid_rd got %0d exp 1", nrd); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_write_enable || resp_valid || !req_ready) bad_cycles++;
    end
    checks++;
    if (bad_cycles !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", bad_cycles); end
    do_req(1'b0, 3'b010, 32'h20, '0);
    checks++;
    if (o_rdata !== ref_mem[8]) begin errors++; $display("FAIL rstmid_word got %h exp %h", o_rdata, ref_mem[8]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] a, d, w, exp_rd, exp_wr;
    logic        exp_err;
    int          widx, exp_cyc, exp_nrd, exp_nwr;
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      a   = (32'($urandom_range(0, 15)) << 2) | 32'(off);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << (AW + 2));
      d   = $urandom;
      widx = int'(a[AW+1:2]);
      w   = ref_mem[widx];
      exp_err = model_err(we, f3, a);
      exp_rd  = (!exp_err && !we) ? model_load(w, f3, off) : 32'h0;
      exp_wr  = model_store(w, d, f3, off);
      if (exp_err)          begin exp_cyc = 1;       exp_nrd = 0; exp_nwr = 0; end
      else if (!we)         begin exp_cyc = 2 + LAT; exp_nrd = 1; exp_nwr = 0; end
      else if (f3 == 3'd2)  begin exp_cyc = 2;       exp_nrd = 0; exp_nwr = 1; end
      else                  begin exp_cyc = 3 + LAT; exp_nrd = 1; exp_nwr = 1; end
      do_req(we, f3, a, d);
      checks++;
      if (o_resp_cyc !== exp_cyc || o_err !== exp_err || o_rdata !== exp_rd) begin
        errors++; $display("FAIL rnd%0d resp we %b f3 %0d addr %h got cyc %0d err %b rdata %h exp cyc %0d err %b rdata %h",
                           n, we, f3, a, o_resp_cyc, o_err, o_rdata, exp_cyc, exp_err, exp_rd);
      end
      checks++;
      if (o_nrd !== exp_nrd || o_nwr !== exp_nwr || o_both !== 0) begin
        errors++; $display("FAIL rnd%0d strobes got rd %0d wr %0d both %0d exp rd %0d wr %0d both 0",
                           n, o_nrd, o_nwr, o_both, exp_nrd, exp_nwr);
      end
      if (exp_nrd == 1) begin
        checks++;
        if (o_rd_cyc !== 1 || o_rd_addr !== AW'(widx)) begin
          errors++; $display("FAIL rnd%0d rd got cyc %0d addr %0d exp cyc 1 addr %0d", n, o_rd_cyc, o_rd_addr, widx);
        end
      end
      if (exp_nwr == 1) begin
        checks++;
        if (o_wr_data !== exp_wr || o_wr_addr !== AW'(widx) || o_wr_cyc !== exp_cyc - 1) begin
          errors++; $display("FAIL rnd%0d wr got data %h addr %0d cyc %0d exp data %h addr %0d cyc %0d",
                             n, o_wr_data, o_wr_addr, o_wr_cyc, exp_wr, widx, exp_cyc - 1);
        end
        ref_mem[widx] = exp_wr;
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== '0) begin
        errors++; $display("FAIL rnd%0d idle got resp_valid %b ready %b addr %0d exp 0 1 0", n, resp_valid, req_ready, mem_addr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_load_extract();
    test_store_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
